// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: validates frames, tracks E0/F0 prefixes, queues {ext,brk,code} events in a FWFT FIFO.
// Latency 1 cycle from rx_done_tick to key_empty falling; a push into a full FIFO without key_rd is dropped with an overflow pulse.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [10:0] frame_in,
    input  logic        key_rd,
    output logic [9:0]  key_data,
    output logic        key_empty,
    output logic        key_full,
    output logic        frame_err,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t state, state_next;

    logic [7:0]    rx_byte;
    logic          frame_ok;
    logic          is_e0;
    logic          is_f0;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          ext_flag;
    logic          brk_flag;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [9:0]    mem [FIFO_DEPTH];

    assign rx_byte  = frame_in[8:1];
    assign frame_ok = ~frame_in[0] & frame_in[10] & (^frame_in[9:1]);
    assign is_e0    = (rx_byte == 8'hE0);
    assign is_f0    = (rx_byte == 8'hF0);
    assign push_req = rx_done_tick & frame_ok & ~is_e0 & ~is_f0;

    assign key_empty = (count == '0);
    assign key_full  = (count == CW'(FIFO_DEPTH));
    assign do_pop    = key_rd & ~key_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push   = push_req & (~key_full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (rx_done_tick) begin
            if (!frame_ok) begin
                state_next = IDLE;
            end else if (is_e0) begin
                state_next = EXT;
            end else if (is_f0) begin
                case (state)
                    IDLE:    state_next = BRK;
                    EXT:     state_next = EXT_BRK;
                    default: state_next = state;
                endcase
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        ext_flag = 1'b0;
        brk_flag = 1'b0;
        case (state)
            EXT:     ext_flag = 1'b1;
            BRK:     brk_flag = 1'b1;
            EXT_BRK: begin
                ext_flag = 1'b1;
                brk_flag = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= rx_done_tick & ~frame_ok;
            overflow  <= push_req & key_full & ~key_rd;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= {ext_flag, brk_flag, rx_byte};
        end
    end

    // Head is forced to zero when empty so reset and idle outputs are deterministic.
    assign key_data = key_empty ? 10'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: prefixes, frame errors, FIFO full/overflow and reset behaviour.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_done_tick = 1'b0;
    logic [10:0] frame_in = 11'd0;
    logic        key_rd = 1'b0;
    logic [9:0]  key_data;
    logic        key_empty;
    logic        key_full;
    logic        frame_err;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .rx_done_tick(rx_done_tick),
        .frame_in(frame_in),
        .key_rd(key_rd),
        .key_data(key_data),
        .key_empty(key_empty),
        .key_full(key_full),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Drive one cycle of stimulus; outputs are then observed on the following negedge.
    task automatic drive(input logic [10:0] f, input logic tick, input logic rd);
        @(negedge clk);
        frame_in     = f;
        rx_done_tick = tick;
        key_rd       = rd;
        @(negedge clk);
        rx_done_tick = 1'b0;
        key_rd       = 1'b0;
    endtask

    task automatic send(input logic [10:0] f);
        drive(f, 1'b1, 1'b0);
    endtask

    task automatic pop();
        drive(11'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", key_empty); end
        vectors++; if (key_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", key_full); end
        vectors++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got err=%b ovf=%b want 0 0", frame_err, overflow); end
        vectors++; if (key_data !== 10'h000) begin miscompares++; $display("FAIL reset_data got %h want 000", key_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_make();
        send(11'h438);
        vectors++; if (key_empty !== 1'b0) begin miscompares++; $display("FAIL make_empty got %b want 0", key_empty); end
        vectors++; if (key_data !== 10'h01C) begin miscompares++; $display("FAIL make_data got %h want 01c", key_data); end
        pop();
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL make_pop got %b want 1", key_empty); end
    endtask

    task automatic test_break();
        send(11'h7E0);
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL brk_prefix_empty got %b want 1", key_empty); end
        send(11'h438);
        vectors++; if (key_data !== 10'h11C) begin miscompares++; $display("FAIL brk_data got %h want 11c", key_data); end
        pop();
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL brk_single got %b want 1", key_empty); end
    endtask

    task automatic test_ext_break();
        send(11'h5C0);
        send(11'h7E0);
        send(11'h4EA);
        vectors++; if (key_data !== 10'h375) begin miscompares++; $display("FAIL extbrk_data got %h want 375", key_data); end
        pop();
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL extbrk_single got %b want 1", key_empty); end
        send(11'h5C0);
        send(11'h4EA);
        vectors++; if (key_data !== 10'h275) begin miscompares++; $display("FAIL ext_data got %h want 275", key_data); end
        pop();
    endtask

    task automatic test_errors();
        send(11'h538);
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL parity_err got %b want 1", frame_err); end
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL parity_noentry got %b want 1", key_empty); end
        @(negedge clk);
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL err_width got %b want 0", frame_err); end
        send(11'h439);
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL start_err got %b want 1", frame_err); end
        send(11'h5C0);
        send(11'h538);
        send(11'h438);
        vectors++; if (key_data !== 10'h01C) begin miscompares++; $display("FAIL err_clears_prefix got %h want 01c", key_data); end
        pop();
        // frame_in changes without rx_done_tick must be ignored
        drive(11'h438, 1'b0, 1'b0);
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL no_tick got %b want 1", key_empty); end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q [$];
        for (int i = 0; i < DEPTH; i++) begin
            send(mk_frame(8'h20 + 8'(i)));
            exp_q.push_back(10'h020 + 10'(i));
        end
        vectors++; if (key_full !== 1'b1) begin miscompares++; $display("FAIL full got %b want 1", key_full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %b want 0", overflow); end
        send(mk_frame(8'h20 + 8'(DEPTH)));
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse got %b want 1", overflow); end
        @(negedge clk);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_width got %b want 0", overflow); end
        drive(mk_frame(8'h30), 1'b1, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(10'h030);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_with_rd got %b want 0", overflow); end
        vectors++; if (key_full !== 1'b1) begin miscompares++; $display("FAIL full_with_rd got %b want 1", key_full); end
        while (exp_q.size() > 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            vectors++; if (key_data !== e) begin miscompares++; $display("FAIL drain got %h want %h", key_data, e); end
            pop();
        end
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL drained got %b want 1", key_empty); end
        pop();
        vectors++; if (key_empty !== 1'b1 || key_full !== 1'b0) begin miscompares++; $display("FAIL rd_empty got e=%b f=%b want 1 0", key_empty, key_full); end
        drive(11'h438, 1'b1, 1'b1);
        vectors++; if (key_empty !== 1'b0 || key_data !== 10'h01C) begin miscompares++; $display("FAIL push_rd_empty got e=%b d=%h want 0 01c", key_empty, key_data); end
        pop();
    endtask

    task automatic test_reset_mid();
        send(11'h5C0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(11'h4EA);
        vectors++; if (key_data !== 10'h075) begin miscompares++; $display("FAIL rst_prefix got %h want 075", key_data); end
        send(11'h438);
        vectors++; if (key_full !== 1'b0 || key_empty !== 1'b0) begin miscompares++; $display("FAIL two_queued got f=%b e=%b want 0 0", key_full, key_empty); end
        @(negedge clk);
        reset = 1'b1;
        frame_in = 11'h438;
        rx_done_tick = 1'b1;
        key_rd = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        key_rd = 1'b0;
        reset = 1'b0;
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL rst_flush got %b want 1", key_empty); end
        vectors++; if (key_data !== 10'h000) begin miscompares++; $display("FAIL rst_flush_data got %h want 000", key_data); end
        @(negedge clk);
        vectors++; if (key_empty !== 1'b1) begin miscompares++; $display("FAIL rst_tick_ignored got %b want 1", key_empty); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext_break();
        test_errors();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, key-event FIFO depth; the value SHALL be a power of two and at least 2.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_done_tick  input  1  one-cycle strobe marking that frame_in holds a complete PS/2 frame.
REQ-005 frame_in  input  11  received frame: bit0 start, bits[8:1] data byte with LSB at bit1, bit9 odd parity, bit10 stop.
REQ-006 key_rd  input  1  consumer pop request for the FIFO head entry.
REQ-007 key_data  output  10  FIFO head entry: {ext, brk, code[7:0]}.
REQ-008 key_empty  output  1  FIFO holds no entries.
REQ-009 key_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 frame_err  output  1  one-cycle pulse when a frame fails its framing or parity check.
REQ-011 overflow  output  1  one-cycle pulse when a key event is dropped because the FIFO is full.

Function
REQ-012 A frame SHALL be evaluated only in a cycle where rx_done_tick=1; frame_in SHALL be ignored in all other cycles.
REQ-013 A frame SHALL be valid only if bit0=0, bit10=1 and the XOR of bits[9:1] is 1.
REQ-014 An invalid frame SHALL pulse frame_err in the next cycle, SHALL be discarded, and SHALL return the prefix FSM to IDLE.
REQ-015 The prefix FSM SHALL have four states: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (after 0xE0 then 0xF0).
REQ-016 On a valid byte 0xE0, the FSM SHALL go from IDLE to EXT; in any other state, 0xE0 SHALL move it to EXT and discard the prior prefix.
REQ-017 On a valid byte 0xF0, the FSM SHALL go IDLE->BRK and EXT->EXT_BRK; in BRK or EXT_BRK it SHALL remain in the current state.
REQ-018 Any other valid byte, including 0xE1, SHALL be a key code: the block SHALL form {ext, brk, code} with ext=1 in EXT or EXT_BRK, brk=1 in BRK or EXT_BRK, push the entry, and return the FSM to IDLE.
REQ-019 The push SHALL occur at the clock edge that samples rx_done_tick, so key_empty falls in the following cycle; input-to-output latency is 1 cycle.
REQ-020 The FIFO SHALL be first-word-fall-through: key_data SHALL show the head entry whenever key_empty=0, and SHALL be don't-care when key_empty=1.
REQ-021 key_rd while key_empty=1 SHALL be ignored, with no pointer change and no error.
REQ-022 If a push coincides with key_rd and the FIFO is full, the pop SHALL occur and the push SHALL be accepted; the count SHALL be unchanged and overflow SHALL not pulse.
REQ-023 If a push occurs when the FIFO is full without key_rd, the entry SHALL be dropped, overflow SHALL pulse one cycle later, and the FSM SHALL still return to IDLE.
REQ-024 If a push coincides with key_rd and the FIFO is empty, the push SHALL succeed and the read SHALL be ignored.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and a count of width log2(FIFO_DEPTH)+1 SHALL drive key_full and key_empty.

Reset
REQ-026 While reset=1, the FSM SHALL be IDLE, the FIFO pointers and count SHALL be 0, key_empty=1, key_full=0, frame_err=0, overflow=0, and key_data=0.
REQ-027 A reset asserted mid-sequence (after a prefix byte) SHALL discard that prefix, and FIFO contents SHALL be lost.
REQ-028 rx_done_tick and key_rd SHALL be ignored in any cycle where reset=1.

Verification
REQ-029 Scenario make: frame 0x438 (0x1C) -> key_data=0x01C one cycle later, key_empty=0; a key_rd pulse then sets key_empty=1.
REQ-030 Scenario break: frames 0x7E0, then 0x438 -> exactly one entry, 0x11C.
REQ-031 Scenario extended break: frames 0x5C0, 0x7E0, 0x4EA -> one entry, 0x375; 0x5C0 followed by 0x4EA -> 0x275.
REQ-032 Scenario errors: frame 0x538 (bad parity) -> frame_err pulse and no entry; frame 0x439 (bad start) -> frame_err; a 0x5C0 prefix followed by a bad frame and then 0x438 -> entry 0x01C (prefix cleared).
REQ-033 Scenario overflow: FIFO_DEPTH+1 valid key frames with no reads -> key_full=1, one overflow pulse, and the first FIFO_DEPTH entries pop in order; push with key_rd while full -> no overflow.
REQ-034 Scenario reset: 0x5C0 is received, then reset is held for 1 cycle, then 0x4EA -> entry 0x075; reset with 2 entries queued -> key_empty=1.
